// File: rtl/inst_encode_loader.sv
// ---------------------------------------------------------------------------
// inst_encode_loader
//
// Purpose
//   Assembles a 32-bit RISC-V instruction word from decoded fields and writes it
//   byte-serially, big-endian (MSB byte at the lowest address), into a byte-wide
//   instruction memory. It is used to load programs into the fetch-side memory.
//   Sequence per word: IDLE (accept) -> ENCODE (1 cycle) -> WRITE (4 cycles).
//
// Parameters
//   ADDR_W     byte-address width of the instruction memory
//   BASE_ADDR  write pointer value after reset
//
// Ports
//   i_clk        clock, all state on rising edge
//   i_rst_n      synchronous reset, active-low
//   i_in_valid   field set valid (accepted in IDLE only)
//   o_in_ready   high while IDLE
//   i_fmt        0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//   i_opcode5    inst[6:2]; inst[1:0] is always 2'b11
//   i_rd/i_rs1/i_rs2, i_funct3, i_f7b5 (inst[30], R-type only), i_imm
//   i_load_addr  load write pointer from i_addr_in (IDLE only)
//   i_addr_in    new pointer value
//   o_wr_en, o_wr_addr, o_wr_byte   byte write port
//   o_word_done  pulse with the last byte of a word
//   o_err        pulse when a field set is rejected (nothing written)
//
// Build option
//   ENC_DECODE_CHECK_EN : when defined, opcode5 must be legal for the format;
//                         otherwise only fmt 6/7 are rejected.
// ---------------------------------------------------------------------------
module inst_encode_loader #(
   parameter int ADDR_W    = 5,
   parameter int BASE_ADDR = 0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [2:0]        i_fmt,
   input  logic [4:0]        i_opcode5,
   input  logic [4:0]        i_rd,
   input  logic [4:0]        i_rs1,
   input  logic [4:0]        i_rs2,
   input  logic [2:0]        i_funct3,
   input  logic              i_f7b5,
   input  logic [31:0]       i_imm,
   input  logic              i_load_addr,
   input  logic [ADDR_W-1:0] i_addr_in,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [7:0]        o_wr_byte,
   output logic              o_word_done,
   output logic              o_err
);

   typedef enum logic [1:0] {S_IDLE, S_ENCODE, S_WRITE} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [1:0]        r_k;
   logic [ADDR_W-1:0] r_ptr;
   logic [31:0]       r_word;
   logic [2:0]        r_fmt;
   logic [4:0]        r_op;
   logic [4:0]        r_rd;
   logic [4:0]        r_rs1;
   logic [4:0]        r_rs2;
   logic [2:0]        r_f3;
   logic              r_f7b5;
   logic [31:0]       r_imm;
   logic [31:0]       w_word;
   logic              w_ok;

   function automatic logic [31:0] encode(
      input logic [2:0]  fmt,
      input logic [4:0]  op5,
      input logic [4:0]  rd,
      input logic [4:0]  rs1,
      input logic [4:0]  rs2,
      input logic [2:0]  f3,
      input logic        f7b5,
      input logic [31:0] imm
   );
      logic [6:0] op;
      op = {op5, 2'b11};
      case (fmt)
         3'd0:    encode = {1'b0, f7b5, 5'b0, rs2, rs1, f3, rd, op};
         3'd1:    encode = {imm[11:0], rs1, f3, rd, op};
         3'd2:    encode = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
         3'd3:    encode = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
         3'd4:    encode = {imm[31:12], rd, op};
         3'd5:    encode = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
         default: encode = 32'd0;
      endcase
   endfunction

   function automatic logic field_set_ok(input logic [2:0] fmt, input logic [4:0] op5);
`ifdef ENC_DECODE_CHECK_EN
      // Only the opcodes the controller decode table maps to each format.
      case (fmt)
         3'd0:    field_set_ok = (op5 == 5'b01100);
         3'd1:    field_set_ok = (op5 == 5'b00000) || (op5 == 5'b00100) || (op5 == 5'b11001);
         3'd2:    field_set_ok = (op5 == 5'b01000);
         3'd3:    field_set_ok = (op5 == 5'b11000);
         3'd4:    field_set_ok = (op5 == 5'b01101) || (op5 == 5'b00101);
         3'd5:    field_set_ok = (op5 == 5'b11011);
         default: field_set_ok = 1'b0;
      endcase
`else
      field_set_ok = (fmt <= 3'd5) && (op5 == op5);
`endif
   endfunction

   assign w_word = encode(r_fmt, r_op, r_rd, r_rs1, r_rs2, r_f3, r_f7b5, r_imm);
   assign w_ok   = field_set_ok(r_fmt, r_op);

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state and outputs; outputs are decoded from registered state only
   always_comb begin
      w_next      = r_state;
      o_in_ready  = 1'b0;
      o_wr_en     = 1'b0;
      o_wr_addr   = r_ptr;
      o_wr_byte   = 8'd0;
      o_word_done = 1'b0;
      o_err       = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_in_ready = 1'b1;
            if (i_in_valid) begin
               w_next = S_ENCODE;
            end
         end
         S_ENCODE: begin
            if (w_ok) begin
               w_next = S_WRITE;
            end else begin
               o_err  = 1'b1;
               w_next = S_IDLE;
            end
         end
         S_WRITE: begin
            o_wr_en   = 1'b1;
            // Address arithmetic wraps modulo 2^ADDR_W by truncation.
            o_wr_addr = r_ptr + ADDR_W'(r_k);
            case (r_k)
               2'd0:    o_wr_byte = r_word[31:24];
               2'd1:    o_wr_byte = r_word[23:16];
               2'd2:    o_wr_byte = r_word[15:8];
               default: o_wr_byte = r_word[7:0];
            endcase
            if (r_k == 2'd3) begin
               o_word_done = 1'b1;
               w_next      = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Control: write pointer and byte counter
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_ptr <= ADDR_W'(BASE_ADDR);
         r_k   <= 2'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // A load in the accepting cycle redirects the accepted word too.
               if (i_load_addr) begin
                  r_ptr <= i_addr_in;
               end
               r_k <= 2'd0;
            end
            S_WRITE: begin
               r_k <= r_k + 2'd1;
               if (r_k == 2'd3) begin
                  r_ptr <= r_ptr + ADDR_W'(4);
               end
            end
            default: r_k <= 2'd0;
         endcase
      end
   end

   // Data: field capture on accept, word build in ENCODE (no reset needed,
   // outputs are gated by state)
   always_ff @(posedge i_clk) begin
      if (r_state == S_IDLE && i_in_valid) begin
         r_fmt  <= i_fmt;
         r_op   <= i_opcode5;
         r_rd   <= i_rd;
         r_rs1  <= i_rs1;
         r_rs2  <= i_rs2;
         r_f3   <= i_funct3;
         r_f7b5 <= i_f7b5;
         r_imm  <= i_imm;
      end
      if (r_state == S_ENCODE) begin
         r_word <= w_word;
      end
   end

endmodule

// File: tb/tb_inst_encode_loader.sv
module tb_inst_encode_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  fmt;
   logic [4:0]  opcode5;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic        f7b5;
   logic [31:0] imm;
   logic        load_addr;
   logic [4:0]  addr_in;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [7:0]  wr_byte;
   logic        word_done;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;

   logic [4:0] m_ptr;
   logic [7:0] m_mem   [32];
   logic [7:0] dut_mem [32];

   inst_encode_loader #(.ADDR_W(5), .BASE_ADDR(0)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_fmt(fmt), .i_opcode5(opcode5), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2),
      .i_funct3(funct3), .i_f7b5(f7b5), .i_imm(imm), .i_load_addr(load_addr),
      .i_addr_in(addr_in), .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_byte(wr_byte),
      .o_word_done(word_done), .o_err(err)
   );

   always #5 clk = ~clk;

   // Capture what actually lands in memory, sampled mid-cycle.
   always @(negedge clk) begin
      if (wr_en === 1'b1) dut_mem[wr_addr] = wr_byte;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Reference word built from field values by shifting bits into place.
   function automatic logic [31:0] model_word(input int f, input int o, input int d, input int s1,
                                              input int s2, input int f3, input int f7,
                                              input logic [31:0] im);
      logic [31:0] w;
      w = 32'(o * 4 + 3);
      case (f)
         0: w = w | 32'(d << 7) | 32'(f3 << 12) | 32'(s1 << 15) | 32'(s2 << 20) | 32'(f7 << 30);
         1: w = w | 32'(d << 7) | 32'(f3 << 12) | 32'(s1 << 15) | ((im & 32'hFFF) << 20);
         2: w = w | ((im & 32'h1F) << 7) | 32'(f3 << 12) | 32'(s1 << 15) | 32'(s2 << 20)
                  | (((im >> 5) & 32'h7F) << 25);
         3: w = w | (((im >> 11) & 1) << 7) | (((im >> 1) & 32'hF) << 8) | 32'(f3 << 12)
                  | 32'(s1 << 15) | 32'(s2 << 20) | (((im >> 5) & 32'h3F) << 25)
                  | (((im >> 12) & 1) << 31);
         4: w = w | 32'(d << 7) | (im & 32'hFFFFF000);
         5: w = w | 32'(d << 7) | (((im >> 12) & 32'hFF) << 12) | (((im >> 11) & 1) << 20)
                  | (((im >> 1) & 32'h3FF) << 21) | (((im >> 20) & 1) << 31);
         default: w = 32'd0;
      endcase
      return w;
   endfunction

   function automatic bit model_ok(input int f, input int o);
      if (f > 5) return 1'b0;
`ifdef ENC_DECODE_CHECK_EN
      case (f)
         0: return o == 12;
         1: return o == 0 || o == 4 || o == 25;
         2: return o == 8;
         3: return o == 24;
         4: return o == 13 || o == 5;
         default: return o == 27;
      endcase
`else
      return (o >= 0);
`endif
   endfunction

   task automatic do_word(input logic [2:0] f, input logic [4:0] o, input logic [4:0] d,
                          input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                          input logic f7, input logic [31:0] im, input logic [31:0] exp_w,
                          input bit exp_e, input bit ld, input logic [4:0] ldv,
                          input bit noise, input string tag);
      logic [4:0] a;
      logic [7:0] b;
      fmt = f; opcode5 = o; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; f7b5 = f7; imm = im;
      in_valid = 1'b1; load_addr = ld; addr_in = ldv;
      chk({tag, " ready_idle"}, 32'(in_ready), 32'd1);
      if (ld) m_ptr = ldv;
      step();
      if (noise) begin
         in_valid = 1'b1; load_addr = 1'b1; addr_in = 5'($urandom);
         fmt = 3'($urandom); opcode5 = 5'($urandom); imm = $urandom;
      end else begin
         in_valid = 1'b0; load_addr = 1'b0;
      end
      chk({tag, " err_enc"}, 32'(err), 32'(exp_e));
      chk({tag, " wren_enc"}, 32'(wr_en), 32'd0);
      chk({tag, " ready_enc"}, 32'(in_ready), 32'd0);
      step();
      in_valid = 1'b0; load_addr = 1'b0;
      if (exp_e) begin
         chk({tag, " ready_after_err"}, 32'(in_ready), 32'd1);
         chk({tag, " wren_after_err"}, 32'(wr_en), 32'd0);
         chk({tag, " err_once"}, 32'(err), 32'd0);
      end else begin
         for (int k = 0; k < 4; k++) begin
            a = m_ptr + 5'(k);
            b = exp_w[31 - 8 * k -: 8];
            chk({tag, " wren"}, 32'(wr_en), 32'd1);
            chk({tag, " addr"}, 32'(wr_addr), 32'(a));
            chk({tag, " byte"}, 32'(wr_byte), 32'(b));
            chk({tag, " done"}, 32'(word_done), 32'(k == 3));
            m_mem[a] = b;
            step();
         end
         m_ptr = m_ptr + 5'd4;
         chk({tag, " ready_after"}, 32'(in_ready), 32'd1);
         chk({tag, " wren_after"}, 32'(wr_en), 32'd0);
      end
   endtask

   typedef struct {
      logic [2:0]  f;
      logic [4:0]  o, d, s1, s2;
      logic [2:0]  f3;
      logic        f7;
      logic [31:0] im;
      logic [31:0] w;
      bit          e;
      bit          ld;
      logic [4:0]  ldv;
   } vec_t;

   vec_t tbl [12];

   initial begin
      logic [31:0] w;
      logic [2:0]  rf;
      logic [4:0]  ro;
      bit          re;

      for (int i = 0; i < 32; i++) begin
         m_mem[i] = 8'd0;
         dut_mem[i] = 8'd0;
      end
      //            f     o         d   s1  s2  f3 f7 imm            word          e  ld ldv
      tbl[0]  = '{3'd0, 5'b01100, 1,  2,  3,  0, 0, 32'd0,         32'h003100B3, 0, 0, 0};
      tbl[1]  = '{3'd3, 5'b11000, 7,  19, 0,  1, 0, 32'd4,         32'h00099263, 0, 0, 0};
      tbl[2]  = '{3'd1, 5'b00100, 1,  0,  0,  0, 0, 32'd5,         32'h00500093, 0, 1, 30};
      tbl[3]  = '{3'd7, 5'b01100, 1,  2,  3,  0, 0, 32'd0,         32'h00000000, 1, 0, 0};
      tbl[4]  = '{3'd2, 5'b01000, 9,  1,  2,  2, 0, 32'd8,         32'h0020A423, 0, 0, 0};
      tbl[5]  = '{3'd4, 5'b01101, 5,  3,  4,  7, 1, 32'h12345ABC,  32'h123452B7, 0, 0, 0};
      tbl[6]  = '{3'd5, 5'b11011, 1,  6,  7,  5, 0, 32'd9,         32'h008000EF, 0, 0, 0};
      tbl[7]  = '{3'd0, 5'b01100, 3,  1,  2,  0, 1, 32'd0,         32'h402081B3, 0, 0, 0};
      tbl[8]  = '{3'd6, 5'b00100, 1,  0,  0,  0, 0, 32'd5,         32'h00000000, 1, 0, 0};
`ifdef ENC_DECODE_CHECK_EN
      tbl[9]  = '{3'd0, 5'b01000, 0,  0,  0,  0, 0, 32'd0,         32'h00000023, 1, 0, 0};
`else
      tbl[9]  = '{3'd0, 5'b01000, 0,  0,  0,  0, 0, 32'd0,         32'h00000023, 0, 0, 0};
`endif
      tbl[10] = '{3'd1, 5'b00100, 2,  2,  0,  0, 0, 32'hFFFFFFFF,  32'hFFF10113, 0, 0, 0};
      tbl[11] = '{3'd1, 5'b00000, 4,  8,  0,  2, 0, 32'h00000010,  32'h01042203, 0, 0, 0};

      // Reset state
      rst_n = 1'b0; in_valid = 1'b0; load_addr = 1'b0; addr_in = '0;
      fmt = '0; opcode5 = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; f7b5 = 1'b0; imm = '0;
      step(); step();
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst wr_en", 32'(wr_en), 32'd0);
      chk("rst word_done", 32'(word_done), 32'd0);
      chk("rst err", 32'(err), 32'd0);
      chk("rst wr_addr", 32'(wr_addr), 32'd0);
      chk("rst wr_byte", 32'(wr_byte), 32'd0);
      rst_n = 1'b1;
      m_ptr = 5'd0;
      step();

      // Directed table
      for (int i = 0; i < 12; i++) begin
         do_word(tbl[i].f, tbl[i].o, tbl[i].d, tbl[i].s1, tbl[i].s2, tbl[i].f3, tbl[i].f7,
                 tbl[i].im, tbl[i].w, tbl[i].e, tbl[i].ld, tbl[i].ldv, 1'b0,
                 $sformatf("tbl%0d", i));
      end

      // Reset during the second byte of a word
      fmt = 3'd0; opcode5 = 5'b01100; rd = 5'd1; rs1 = 5'd2; rs2 = 5'd3; funct3 = 3'd0;
      f7b5 = 1'b0; imm = 32'd0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      chk("rstmid byte0 wren", 32'(wr_en), 32'd1);
      m_mem[m_ptr] = 8'h00;
      step();
      chk("rstmid byte1 wren", 32'(wr_en), 32'd1);
      chk("rstmid byte1 addr", 32'(wr_addr), 32'(m_ptr + 5'd1));
      m_mem[m_ptr + 5'd1] = 8'h31;
      rst_n = 1'b0;
      step();
      chk("rstmid wr_en", 32'(wr_en), 32'd0);
      chk("rstmid in_ready", 32'(in_ready), 32'd1);
      chk("rstmid wr_addr", 32'(wr_addr), 32'd0);
      chk("rstmid done", 32'(word_done), 32'd0);
      rst_n = 1'b1;
      m_ptr = 5'd0;
      do_word(3'd1, 5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 32'h00500093, 1'b0, 1'b0,
              5'd0, 1'b0, "after_rst");

      // Back-to-back: in_valid held high across three words, starting at address 0
      fmt = 3'd0; opcode5 = 5'b01100; rd = 5'd1; rs1 = 5'd2; rs2 = 5'd3; funct3 = 3'd0;
      f7b5 = 1'b0; imm = 32'd0;
      in_valid = 1'b1; load_addr = 1'b1; addr_in = 5'd0;
      m_ptr = 5'd0;
      w = 32'h003100B3;
      for (int n = 0; n < 3; n++) begin
         chk("b2b ready", 32'(in_ready), 32'd1);
         step();
         load_addr = 1'b0;
         if (n == 2) in_valid = 1'b0;
         chk("b2b enc ready", 32'(in_ready), 32'd0);
         step();
         for (int k = 0; k < 4; k++) begin
            chk("b2b wren", 32'(wr_en), 32'd1);
            chk("b2b addr", 32'(wr_addr), 32'(4 * n + k));
            chk("b2b byte", 32'(wr_byte), 32'(w[31 - 8 * k -: 8]));
            m_mem[5'(4 * n + k)] = w[31 - 8 * k -: 8];
            step();
         end
      end
      m_ptr = 5'd12;
      step();
      chk("b2b no 4th accept", 32'(in_ready), 32'd1);

      // Randomized words against the reference model
      for (int i = 0; i < 40; i++) begin
         rf = 3'($urandom_range(0, 7));
         ro = 5'($urandom);
`ifdef ENC_DECODE_CHECK_EN
         if ($urandom_range(0, 1) == 1) begin
            case (rf)
               3'd0: ro = 5'b01100;
               3'd1: ro = 5'b00000;
               3'd2: ro = 5'b01000;
               3'd3: ro = 5'b11000;
               3'd4: ro = 5'b00101;
               default: ro = 5'b11011;
            endcase
         end
`endif
         rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
         funct3 = 3'($urandom); f7b5 = 1'($urandom); imm = $urandom;
         re = !model_ok(int'(rf), int'(ro));
         w = model_word(int'(rf), int'(ro), int'(rd), int'(rs1), int'(rs2), int'(funct3),
                        int'(f7b5), imm);
         do_word(rf, ro, rd, rs1, rs2, funct3, f7b5, imm, w, re,
                 ($urandom_range(0, 3) == 0), 5'($urandom), 1'($urandom),
                 $sformatf("rnd%0d", i));
      end

      // Final memory image
      step();
      for (int i = 0; i < 32; i++) begin
         chk($sformatf("mem[%0d]", i), 32'(dut_mem[i]), 32'(m_mem[i]));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
